// File: rtl/exec_muldiv_stage_if.sv
// exec_muldiv_stage_if: decode/write-back to execute-stage signal bundle.
// The master side drives the decoded instruction and the write-back port;
// the slave side (the execute stage) returns the registered ex_* results.
interface exec_muldiv_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          id_Valid;
  logic [5:0]    id_OpCode;
  logic [5:0]    id_ALUOp;
  logic [1:0]    id_ALUSrcSel;
  logic [4:0]    id_SHF;
  logic [RW-1:0] id_RS, id_RT, id_RD;
  logic          id_RegDestSel, id_RegWriteSel, id_MemRd, id_MemWr, id_MemRegSel;
  logic [DW-1:0] id_RFOutA, id_RFOutB, id_SignExtImm, id_ZeroExtImm;

  logic [DW-1:0] wr_Data;
  logic [RW-1:0] wr_RegDest;
  logic          wr_RegWriteSel;

  logic          ex_Stall;
  logic          ex_Valid, ex_RegWriteSel, ex_MemRd, ex_MemWr, ex_MemRegSel;
  logic [DW-1:0] ex_ALUOut, ex_OpB_pre;
  logic [RW-1:0] ex_RegDest;
  logic          mul_Busy;

  modport master (
    output id_Valid, id_OpCode, id_ALUOp, id_ALUSrcSel, id_SHF,
           id_RS, id_RT, id_RD,
           id_RegDestSel, id_RegWriteSel, id_MemRd, id_MemWr, id_MemRegSel,
           id_RFOutA, id_RFOutB, id_SignExtImm, id_ZeroExtImm,
           wr_Data, wr_RegDest, wr_RegWriteSel,
    input  ex_Stall, ex_Valid, ex_RegWriteSel, ex_MemRd, ex_MemWr, ex_MemRegSel,
           ex_ALUOut, ex_OpB_pre, ex_RegDest, mul_Busy
  );

  modport slave (
    input  id_Valid, id_OpCode, id_ALUOp, id_ALUSrcSel, id_SHF,
           id_RS, id_RT, id_RD,
           id_RegDestSel, id_RegWriteSel, id_MemRd, id_MemWr, id_MemRegSel,
           id_RFOutA, id_RFOutB, id_SignExtImm, id_ZeroExtImm,
           wr_Data, wr_RegDest, wr_RegWriteSel,
    output ex_Stall, ex_Valid, ex_RegWriteSel, ex_MemRd, ex_MemWr, ex_MemRegSel,
           ex_ALUOut, ex_OpB_pre, ex_RegDest, mul_Busy
  );
endinterface

// File: rtl/exec_muldiv_stage.sv
// exec_muldiv_stage: execute stage with operand forwarding, load-use stall,
// a single-cycle ALU and a multi-cycle multiply/divide unit that owns HI/LO.
//
// state | meaning
// IDLE  | nothing in flight; HI/LO readable, MTHI/MTLO and new MULT/DIV accepted
// RUN   | one shift-add (mul) or restoring shift-subtract (div) step per cycle
// FIX   | apply result signs, write HI/LO, return to IDLE
module exec_muldiv_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input logic clock,
  input logic reset,
  exec_muldiv_stage_if.slave bus
);
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state;
  logic [CW-1:0]   stepCount;
  logic [DW-1:0]   accHi, accLo, mdOpB, hi, lo;
  logic            opIsDiv, negQ, negR, divZero;

  logic            exValid, exRegWriteSel, exMemRd, exMemWr, exMemRegSel;
  logic [DW-1:0]   exALUOut, exOpBPre;
  logic [RW-1:0]   exRegDest;

  logic            isRType, isMulDiv, isSignedOp, isMfhi, isMflo, isMthi, isMtlo, isHiLoOp;
  logic            loadUse, busyStall, stall, accept;
  logic [RW-1:0]   regDest;
  logic [DW-1:0]   fwdA, fwdB, opB, aluOut, magA, magB, divDiff;
  logic [DW:0]     mulSum, divShift;
  logic            divGe;
  logic [2*DW-1:0] product, productFix;

  assign isRType    = bus.id_OpCode == 6'h00;
  assign isMulDiv   = isRType && bus.id_ALUOp[5:2] == 4'b0110;
  assign isSignedOp = ~bus.id_ALUOp[0];
  assign isMfhi     = isRType && bus.id_ALUOp == 6'h10;
  assign isMthi     = isRType && bus.id_ALUOp == 6'h11;
  assign isMflo     = isRType && bus.id_ALUOp == 6'h12;
  assign isMtlo     = isRType && bus.id_ALUOp == 6'h13;
  assign isHiLoOp   = isMulDiv | isMfhi | isMflo | isMthi | isMtlo;
  assign regDest    = bus.id_RegDestSel ? bus.id_RD : bus.id_RT;

  // Forwarding muxes: the instruction in EX wins over write-back; r0 never matches.
  always_comb begin
    fwdA = bus.id_RFOutA;
    fwdB = bus.id_RFOutB;
    if (bus.id_RS != '0 && exRegWriteSel && !exMemRd && exRegDest == bus.id_RS)
      fwdA = exALUOut;
    else if (bus.id_RS != '0 && bus.wr_RegWriteSel && bus.wr_RegDest == bus.id_RS)
      fwdA = bus.wr_Data;
    if (bus.id_RT != '0 && exRegWriteSel && !exMemRd && exRegDest == bus.id_RT)
      fwdB = exALUOut;
    else if (bus.id_RT != '0 && bus.wr_RegWriteSel && bus.wr_RegDest == bus.id_RT)
      fwdB = bus.wr_Data;
  end

  assign opB = (bus.id_ALUSrcSel == 2'b01) ? bus.id_SignExtImm :
               (bus.id_ALUSrcSel == 2'b10) ? bus.id_ZeroExtImm : fwdB;

  // A load result is not ready for one cycle; HI/LO users wait for the unit to drain.
  assign loadUse   = bus.id_Valid && exMemRd && exRegDest != '0 &&
                     (exRegDest == bus.id_RS || exRegDest == bus.id_RT);
  assign busyStall = bus.id_Valid && isHiLoOp && state != IDLE;
  assign stall     = loadUse | busyStall;
  assign accept    = bus.id_Valid & ~stall;

  // Single-cycle ALU: R-type decoded on funct, everything else on opcode.
  always_comb begin
    aluOut = fwdA + opB;
    if (isRType) begin
      case (bus.id_ALUOp)
        6'h00:        aluOut = opB << bus.id_SHF;
        6'h02:        aluOut = opB >> bus.id_SHF;
        6'h03:        aluOut = $signed(opB) >>> bus.id_SHF;
        6'h04:        aluOut = opB << fwdA[4:0];
        6'h06:        aluOut = opB >> fwdA[4:0];
        6'h07:        aluOut = $signed(opB) >>> fwdA[4:0];
        6'h22, 6'h23: aluOut = fwdA - opB;
        6'h24:        aluOut = fwdA & opB;
        6'h25:        aluOut = fwdA | opB;
        6'h26:        aluOut = fwdA ^ opB;
        6'h27:        aluOut = ~(fwdA | opB);
        6'h2A:        aluOut = DW'($signed(fwdA) < $signed(opB));
        6'h2B:        aluOut = DW'(fwdA < opB);
        default:      aluOut = fwdA + opB;
      endcase
    end else begin
      case (bus.id_OpCode)
        6'h0A:   aluOut = DW'($signed(fwdA) < $signed(opB));
        6'h0B:   aluOut = DW'(fwdA < opB);
        6'h0C:   aluOut = fwdA & opB;
        6'h0D:   aluOut = fwdA | opB;
        6'h0E:   aluOut = fwdA ^ opB;
        default: aluOut = fwdA + opB;
      endcase
    end
  end

  // Iteration datapath: accHi/accLo hold product or remainder/quotient.
  assign magA       = fwdA[DW-1] ? -fwdA : fwdA;
  assign magB       = opB[DW-1] ? -opB : opB;
  assign mulSum     = {1'b0, accHi} + (accLo[0] ? {1'b0, mdOpB} : '0);
  assign divShift   = {accHi, accLo[DW-1]};
  assign divGe      = divShift >= {1'b0, mdOpB};
  assign divDiff    = divShift[DW-1:0] - mdOpB;
  assign product    = {accHi, accLo};
  assign productFix = negQ ? -product : product;

  // Multiply/divide FSM plus HI/LO ownership, including MTHI/MTLO writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      stepCount <= '0;
      accHi     <= '0;
      accLo     <= '0;
      mdOpB     <= '0;
      hi        <= '0;
      lo        <= '0;
      opIsDiv   <= 1'b0;
      negQ      <= 1'b0;
      negR      <= 1'b0;
      divZero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && isMulDiv) begin
            state     <= RUN;
            stepCount <= '0;
            accHi     <= '0;
            accLo     <= isSignedOp ? magA : fwdA;
            mdOpB     <= isSignedOp ? magB : opB;
            opIsDiv   <= bus.id_ALUOp[1];
            negQ      <= isSignedOp & (fwdA[DW-1] ^ opB[DW-1]);
            negR      <= isSignedOp & fwdA[DW-1];
            divZero   <= opB == '0;
          end else if (accept && isMthi) begin
            hi <= fwdA;
          end else if (accept && isMtlo) begin
            lo <= fwdA;
          end
        end
        RUN: begin
          if (opIsDiv) begin
            accHi <= divGe ? divDiff : divShift[DW-1:0];
            accLo <= {accLo[DW-2:0], divGe};
          end else begin
            accHi <= mulSum[DW:1];
            accLo <= {mulSum[0], accLo[DW-1:1]};
          end
          stepCount <= stepCount + 1'b1;
          if (stepCount == CW'(DW - 1)) state <= FIX;
        end
        FIX: begin
          if (opIsDiv) begin
            hi <= negR ? -accHi : accHi;
            lo <= divZero ? '1 : (negQ ? -accLo : accLo);
          end else begin
            hi <= productFix[2*DW-1:DW];
            lo <= productFix[DW-1:0];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // EX pipeline register: accepted instructions load it, otherwise a bubble.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exValid       <= 1'b0;
      exRegWriteSel <= 1'b0;
      exMemRd       <= 1'b0;
      exMemWr       <= 1'b0;
      exMemRegSel   <= 1'b0;
      exALUOut      <= '0;
      exOpBPre      <= '0;
      exRegDest     <= '0;
    end else if (accept) begin
      exValid       <= 1'b1;
      exRegWriteSel <= (isMfhi | isMflo) ? 1'b1 :
                       (isMulDiv | isMthi | isMtlo) ? 1'b0 : bus.id_RegWriteSel;
      exMemRd       <= bus.id_MemRd;
      exMemWr       <= bus.id_MemWr;
      exMemRegSel   <= bus.id_MemRegSel;
      exALUOut      <= isMfhi ? hi : isMflo ? lo : aluOut;
      exOpBPre      <= fwdB;
      exRegDest     <= regDest;
    end else begin
      exValid       <= 1'b0;
      exRegWriteSel <= 1'b0;
      exMemRd       <= 1'b0;
      exMemWr       <= 1'b0;
    end
  end

  assign bus.ex_Stall       = stall;
  assign bus.ex_Valid       = exValid;
  assign bus.ex_RegWriteSel = exRegWriteSel;
  assign bus.ex_MemRd       = exMemRd;
  assign bus.ex_MemWr       = exMemWr;
  assign bus.ex_MemRegSel   = exMemRegSel;
  assign bus.ex_ALUOut      = exALUOut;
  assign bus.ex_OpB_pre     = exOpBPre;
  assign bus.ex_RegDest     = exRegDest;
  assign bus.mul_Busy       = state != IDLE;
endmodule
